// File: rtl/seg7_capture.sv
// Recovers the hex digit shown on an asynchronous 7-segment bus, checks it counts up by one, and flags illegal patterns.
// Latency: new_digit is high after edge STABLE_CYCLES+2 for a pattern stable before edge 1. There is no backpressure; it is a passive monitor.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int DWELL_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             seg_in,
  input  logic                   clear,
  output logic [3:0]             digit,
  output logic                   digit_valid,
  output logic                   new_digit,
  output logic [DWELL_WIDTH-1:0] dwell_ticks,
  output logic                   seq_error,
  output logic                   bad_pattern,
  output logic                   blank,
  output logic [7:0]             change_count
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [6:0]             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, acc_q, acc_d;
  logic [7:0]             stab_q, stab_d;
  state_t                 state_q, state_d;
  logic [3:0]             digit_q, digit_d;
  logic                   new_digit_q, new_digit_d;
  logic [DWELL_WIDTH-1:0] run_q, run_d, dwell_q, dwell_d, run_inc;
  logic                   seq_err_q, seq_err_d, bad_q, bad_d, blank_q, blank_d;
  logic [7:0]             cnt_q, cnt_d;

  logic       accept, acc_valid, acc_blank, acc_bad, seq_set;
  logic [3:0] dec_val, digit_inc;
  logic       dec_blank, dec_bad;

  always_comb begin
    dec_val   = 4'h0;
    dec_blank = 1'b0;
    dec_bad   = 1'b0;
    case (s2_q)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_bad = 1'b1;
    endcase
  end

  always_comb begin
    s1_d   = seg_in;
    s2_d   = s1_q;
    prev_d = s2_q;

    if (s2_q != prev_q)        stab_d = 8'd1;
    else if (stab_q == STAB_MAX) stab_d = stab_q;
    else                       stab_d = stab_q + 8'd1;

    // Comparing against the last accepted pattern stops a held pattern from re-accepting.
    accept    = (stab_d == STAB_MAX) && (s2_q != acc_q);
    acc_valid = accept && !dec_blank && !dec_bad;
    acc_blank = accept && dec_blank;
    acc_bad   = accept && dec_bad;

    digit_inc = digit_q + 4'd1;
    run_inc   = (&run_q) ? run_q : run_q + 1'b1;

    acc_d       = accept ? s2_q : acc_q;
    state_d     = state_q;
    digit_d     = acc_valid ? dec_val : digit_q;
    new_digit_d = acc_valid;
    run_d       = '0;
    dwell_d     = dwell_q;
    seq_set     = 1'b0;

    case (state_q)
      SEARCH: begin
        if (acc_valid) state_d = LOCKED;
      end
      LOCKED: begin
        run_d = run_inc;
        if (acc_valid) begin
          dwell_d = run_inc;
          run_d   = '0;
          seq_set = (dec_val != digit_inc);
        end
        if (acc_blank || acc_bad) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    // A set event in the same cycle as clear wins over the clear.
    seq_err_d = seq_set | (seq_err_q & ~clear);
    bad_d     = acc_bad | (bad_q & ~clear);
    blank_d   = accept ? dec_blank : blank_q;
    cnt_d     = (clear ? 8'd0 : cnt_q) + {7'd0, acc_valid};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      prev_q      <= '0;
      acc_q       <= '0;
      stab_q      <= '0;
      state_q     <= SEARCH;
      digit_q     <= '0;
      new_digit_q <= 1'b0;
      run_q       <= '0;
      dwell_q     <= '0;
      seq_err_q   <= 1'b0;
      bad_q       <= 1'b0;
      blank_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      stab_q      <= stab_d;
      state_q     <= state_d;
      digit_q     <= digit_d;
      new_digit_q <= new_digit_d;
      run_q       <= run_d;
      dwell_q     <= dwell_d;
      seq_err_q   <= seq_err_d;
      bad_q       <= bad_d;
      blank_q     <= blank_d;
      cnt_q       <= cnt_d;
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = (state_q == LOCKED);
  assign new_digit    = new_digit_q;
  assign dwell_ticks  = dwell_q;
  assign seq_error    = seq_err_q;
  assign bad_pattern  = bad_q;
  assign blank        = blank_q;
  assign change_count = cnt_q;

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side companion to the counter/seg7 display path: watches a 7-segment bus and recovers the hex digit being shown.
- Synchronises and debounces the segment pattern, decodes it to 0–F, and measures dwell time between digit changes.
- Checks that successive digits increment by one (mod 16) and flags illegal patterns.
- Used as an on-chip self-check or loopback monitor for the display counter.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required to accept a pattern (legal range 1..255).
- DWELL_WIDTH, 24, width of the dwell-time counter and of the dwell_ticks output.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- seg_in  input  7  segment bus, bit0=a … bit6=g, active high, asynchronous to clk
- clear  input  1  synchronous clear of sticky flags and change_count
- digit  output  4  last accepted decoded value
- digit_valid  output  1  high while in LOCKED
- new_digit  output  1  one-cycle pulse on each accepted digit
- dwell_ticks  output  DWELL_WIDTH  clk cycles between the last two accepted digits
- seq_error  output  1  sticky: an accepted digit was not previous+1 mod 16
- bad_pattern  output  1  sticky: a non-hex, non-blank pattern was accepted
- blank  output  1  high while the accepted pattern is 0x00
- change_count  output  8  accepted valid digits, wraps 255→0

Behaviour:
- Reset (asynchronous, active-high):
  - all outputs 0, synchroniser and all counters 0, FSM in SEARCH.
  - Reset asserted mid-operation aborts any pending acceptance.
- Synchroniser: two flops on seg_in (s1, s2).
- Stability filter:
  - stab_cnt resets to 1 when s2 differs from its previous value; otherwise it increments, saturating at STABLE_CYCLES.
  - A pattern is accepted on the edge where stab_cnt reaches STABLE_CYCLES and s2 differs from the last accepted pattern.
  - A pattern that is held does not re-accept.
- Latency: with seg_in stable before edge 1, new_digit is high after edge STABLE_CYCLES+2, for exactly one cycle.
- Decode table (pattern → value):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F
  - 00 is blank; any other pattern is bad.
- FSM states: SEARCH, LOCKED.
- SEARCH:
  - valid accept → digit updated, new_digit pulse, change_count+1, go to LOCKED.
  - dwell_ticks is not updated and seq_error is not checked.
  - run_cnt is cleared to 0.
- LOCKED:
  - run_cnt increments every cycle, saturating at all-ones (no wrap).
  - On valid accept:
    - dwell_ticks ← run_cnt+1 (saturating); run_cnt ← 0.
    - digit updated, new_digit pulse, change_count+1.
    - If value ≠ (digit+1) mod 16 then seq_error ← 1. F→0 is legal.
  - On blank accept: blank ← 1, digit_valid ← 0, go to SEARCH, no error. digit holds its last value.
  - On bad accept: bad_pattern ← 1, digit_valid ← 0, go to SEARCH. digit holds.
- In SEARCH, a bad accept sets bad_pattern and a blank accept sets blank; the state stays SEARCH.
- blank clears on the next non-blank accept.
- clear:
  - zeroes seq_error, bad_pattern and change_count next edge.
  - If a set event happens the same cycle, the set wins and change_count becomes 1 if that event is a valid accept.
- Glitches shorter than STABLE_CYCLES samples never produce an accept or a flag.

Test Plan:
- Reset, hold seg_in=0x3F (STABLE_CYCLES=4):
  - new_digit pulses after edge 6, digit=0, digit_valid=1, change_count=1, dwell_ticks=0.
- Step 0x3F→0x06 with 100 cycles between changes:
  - digit=1, dwell_ticks=100, seq_error=0.
  - Continue through 0x71→0x3F: F→0 gives no seq_error, change_count=17.
- From LOCKED on digit 2 (0x5B), apply 0x66 (digit 4):
  - seq_error=1, digit=4, stays LOCKED.
  - Pulse clear: seq_error=0, change_count=0.
- From LOCKED on digit 0 (0x3F):
  - 2-cycle pulse to 0x7F then back to 0x3F: no new_digit, no flags.
  - 0x01 held ≥4 cycles: bad_pattern=1, digit_valid=0, digit still 0.
  - 0x00 held: blank=1, state SEARCH.
- Hold one digit for more than 2^24 cycles, then change: dwell_ticks=0xFFFFFF.
- Assert reset mid-filter (stab_cnt=3): all outputs 0 immediately; no accept from the aborted pattern until it is re-held for the full latency.
